// File: rtl/smaesh_out_serializer_pkg.sv
// Shared definitions for the masked-AES output serializer: share geometry, sizing helpers
// and the control FSM state encoding.
package smaesh_out_serializer_pkg;

  localparam int unsigned ShareBits = 128;

  typedef enum logic {StIdle, StSend} state_e;

  // Words needed to carry a full d-share block at width w.
  function automatic int unsigned calc_nwords(int unsigned d, int unsigned w);
    return (ShareBits * d) / w;
  endfunction

  function automatic int unsigned calc_cnt_width(int unsigned nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

  function automatic bit w_is_legal(int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/smaesh_out_serializer_if.sv
// Block-in / word-out stream bundle of the serializer; the serializer uses the slave view.
interface smaesh_out_serializer_if #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 32
);
  localparam int unsigned IdxW = (d > 1) ? $clog2(d) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [128*d-1:0]     in_shares_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [IdxW-1:0]      out_share_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_shares_data, out_ready,
    input  in_ready, out_valid, out_data, out_share_idx, out_last
  );

  modport slave (
    input  in_valid, in_shares_data, out_ready,
    output in_ready, out_valid, out_data, out_share_idx, out_last
  );
endinterface

// File: rtl/smaesh_word_mux.sv
// NWORDS:1 selector of W-bit slices from the block buffer; the only path from buffer to output.
module smaesh_word_mux #(
  parameter int unsigned NWORDS = 8,
  parameter int unsigned W      = 32,
  parameter int unsigned CW     = 3
) (
  input  logic [NWORDS*W-1:0] data,
  input  logic [CW-1:0]       sel,
  output logic [W-1:0]        word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (sel == CW'(i)) word = data[i*W +: W];
    end
  end

endmodule

// File: rtl/smaesh_out_serializer.sv
// Buffers one shared ciphertext block and drains it as W-bit words, share by share,
// zeroizing the buffer once a block has left with nothing queued behind it.
module smaesh_out_serializer
  import smaesh_out_serializer_pkg::*;
#(
  parameter int unsigned d = 2,
  parameter int unsigned W = 32
) (
  input logic                   clk,
  input logic                   rst,
  smaesh_out_serializer_if.slave bus
);

  localparam int unsigned NWORDS = calc_nwords(d, W);
  localparam int unsigned CntW   = calc_cnt_width(NWORDS);
  localparam int unsigned Wps    = ShareBits / W;
  localparam int unsigned IdxW   = (d > 1) ? $clog2(d) : 1;
  localparam int unsigned BufW   = ShareBits * d;
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  if (!w_is_legal(W)) begin : g_bad_w
    $fatal(1, "smaesh_out_serializer: W must be one of 8,16,32,64,128");
  end
  if (d < 2) begin : g_bad_d
    $fatal(1, "smaesh_out_serializer: d must be at least 2");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [W-1:0]      word;
  logic              sending;
  logic              last_word;
  logic              out_hs;
  logic              in_ready;

  smaesh_word_mux #(
    .NWORDS (NWORDS),
    .W      (W),
    .CW     (CntW)
  ) u_word_mux (
    .data (buf_q),
    .sel  (cnt_q),
    .word (word)
  );

  always_comb begin
    sending   = (state_q == StSend);
    last_word = sending && (cnt_q == LastCnt);
    out_hs    = sending && bus.out_ready;
    // Accept the next block only while idle or as the final word leaves, so there is no bubble.
    in_ready  = (state_q == StIdle) || (out_hs && last_word);

    bus.in_ready      = in_ready;
    bus.out_valid     = sending;
    bus.out_last      = last_word;
    bus.out_data      = sending ? word : '0;
    bus.out_share_idx = sending ? IdxW'(cnt_q / CntW'(Wps)) : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          state_d = StSend;
          cnt_d   = '0;
          buf_d   = bus.in_shares_data;
        end
      end
      StSend: begin
        if (out_hs) begin
          if (!last_word) begin
            cnt_d = cnt_q + CntW'(1);
          end else if (bus.in_valid) begin
            cnt_d = '0;
            buf_d = bus.in_shares_data;
          end else begin
            // No share material may outlive the block.
            state_d = StIdle;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_smaesh_out_serializer.sv
// Randomized self-checking bench: two serializer configurations against a word-list reference model.
module tb_smaesh_out_serializer;
  import smaesh_out_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smaesh_out_serializer_if #(.d(2), .W(32))  a_if ();
  smaesh_out_serializer_if #(.d(3), .W(128)) b_if ();

  smaesh_out_serializer #(.d(2), .W(32)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  smaesh_out_serializer #(.d(3), .W(128)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned idx;
    logic        last;
  } word_t;

  word_t        exp_q[$];
  logic [255:0] blk_q[$];

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Reference: share 0 first, then share 1; each share LSB word first.
  function automatic void expect_block(input logic [255:0] blk);
    word_t w;
    for (int s = 0; s < 2; s++) begin
      logic [127:0] share;
      share = 128'(blk >> (128 * s));
      for (int j = 0; j < 4; j++) begin
        w.data = 32'(share >> (32 * j));
        w.idx  = s;
        w.last = (s == 1) && (j == 3);
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic run_a(input int max_cycles, input int stall_pct, input bit must_finish);
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        exp_in_ready;
    int          n = 0;
    while ((blk_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      @(posedge clk);
      #1;
      a_if.in_valid       = (blk_q.size() > 0);
      a_if.in_shares_data = (blk_q.size() > 0) ? blk_q[0] : rand256();
      a_if.out_ready      = ($urandom_range(99) >= stall_pct);
      #1;
      if (prev_stall) begin
        check("stall_valid", a_if.out_valid, 1'b1);
        check("stall_data", a_if.out_data, prev_data);
      end
      check("out_valid", a_if.out_valid, exp_q.size() > 0);
      exp_in_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && a_if.out_ready);
      check("in_ready", a_if.in_ready, exp_in_ready);
      if (a_if.out_valid && exp_q.size() > 0) begin
        check("out_data", a_if.out_data, exp_q[0].data);
        check("out_share_idx", a_if.out_share_idx, exp_q[0].idx);
        check("out_last", a_if.out_last, exp_q[0].last);
        if (a_if.out_ready) void'(exp_q.pop_front());
      end
      if (a_if.in_valid && a_if.in_ready) expect_block(blk_q.pop_front());
      prev_stall = a_if.out_valid && !a_if.out_ready;
      prev_data  = a_if.out_data;
      n++;
    end
    if (must_finish) check("drain_timeout", blk_q.size() + exp_q.size(), 0);
  endtask

  task automatic check_a_drained(input string tag);
    @(posedge clk);
    #1;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
    #1;
    check({tag, "_state"}, u_a.state_q, StIdle);
    check({tag, "_buf"}, u_a.buf_q, 0);
    check({tag, "_valid"}, a_if.out_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] bblk;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.in_shares_data = '0;
    b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; b_if.in_shares_data = '0;

    #12;
    check("rst_out_valid", a_if.out_valid, 1'b0);
    check("rst_out_last", a_if.out_last, 1'b0);
    check("rst_out_data", a_if.out_data, 0);
    check("rst_share_idx", a_if.out_share_idx, 0);
    check("rst_buf", u_a.buf_q, 0);
    check("rst_cnt", u_a.cnt_q, 0);
    check("rst_b_valid", b_if.out_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("in_ready_after_reset", a_if.in_ready, 1'b1);

    // Directed block: share0 known pattern, share1 zero.
    blk_q.push_back({128'h0, 128'h00112233_44556677_8899AABB_CCDDEEFF});
    run_a(40, 0, 1);
    check_a_drained("drain1");

    // Back-to-back blocks with in_valid held and no stalls.
    blk_q.push_back(rand256());
    blk_q.push_back(rand256());
    run_a(60, 0, 1);
    check_a_drained("drain2");

    // Random 50% output stalls over several blocks.
    for (int i = 0; i < 3; i++) blk_q.push_back(rand256());
    run_a(600, 50, 1);
    check_a_drained("drain3");

    // Reset while the third word of a block is on the output.
    blk_q.push_back(rand256());
    run_a(3, 0, 0);
    @(posedge clk);
    #1;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b0;
    #2;
    check("pre_rst_valid", a_if.out_valid, 1'b1);
    check("pre_rst_word", a_if.out_data, exp_q[0].data);
    rst = 1'b1;
    #1;
    check("midrst_valid", a_if.out_valid, 1'b0);
    check("midrst_data", a_if.out_data, 0);
    check("midrst_last", a_if.out_last, 1'b0);
    check("midrst_buf", u_a.buf_q, 0);
    exp_q.delete();
    blk_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    blk_q.push_back(rand256());
    run_a(40, 0, 1);
    check_a_drained("drain4");

    // d=3, W=128: one word per share.
    for (int i = 0; i < 12; i++) bblk[32*i +: 32] = $urandom();
    @(posedge clk);
    #1;
    b_if.in_valid       = 1'b1;
    b_if.in_shares_data = bblk;
    b_if.out_ready      = 1'b1;
    #1;
    check("b_in_ready", b_if.in_ready, 1'b1);
    @(posedge clk);
    #1 b_if.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("b_valid", b_if.out_valid, 1'b1);
      check("b_data", b_if.out_data, 128'(bblk >> (128 * k)));
      check("b_share_idx", b_if.out_share_idx, k);
      check("b_last", b_if.out_last, k == 2);
      @(posedge clk);
      #1;
    end
    #1;
    check("b_done_valid", b_if.out_valid, 1'b0);
    check("b_done_buf", u_b.buf_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
